// File: rtl/pp_pipeline_accel_fifo_to_axis.sv
// Reader-side adapter: drains a start-triggered packet of pkt_len words from a
// shift-register stream FIFO (empty_n/read/dout) and presents it as an
// AXI4-Stream master with generated tlast. A 2-entry registered buffer keeps
// fifo_read independent of m_axis_tready while sustaining one beat per cycle.
module pp_pipeline_accel_fifo_to_axis #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep
);

  localparam int unsigned OCC_WIDTH = 2;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state;
  logic [OCC_WIDTH-1:0]   occ;
  logic [LEN_WIDTH-1:0]   rd_rem;
  logic [LEN_WIDTH-1:0]   tx_rem;
  logic [DATA_WIDTH-1:0]  tail_data;
  logic                   tail_last;
  logic                   pop;
  logic                   accept;
  logic                   pop_last;

  // Pop only while a packet still needs words and the buffer has room.
  assign fifo_read = (state == RUN) && fifo_empty_n &&
                     (occ != OCC_WIDTH'(2)) && (rd_rem != '0);
  assign pop       = fifo_read;
  assign accept    = m_axis_tvalid && m_axis_tready;
  assign pop_last  = (rd_rem == LEN_WIDTH'(1));

  assign m_axis_tkeep = '1;

  // Packet sequencing: beat counters, busy and the one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_rem <= '0;
      tx_rem <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pkt_len != '0) begin
              state  <= RUN;
              rd_rem <= pkt_len;
              tx_rem <= pkt_len;
              busy   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop) begin
            rd_rem <= rd_rem - LEN_WIDTH'(1);
          end
          if (accept) begin
            tx_rem <= tx_rem - LEN_WIDTH'(1);
            if (tx_rem == LEN_WIDTH'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer: head drives the AXIS outputs, tail holds the second word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      tail_data     <= '0;
      tail_last     <= 1'b0;
    end else begin
      case ({pop, accept})
        2'b10: begin
          if (occ == '0) begin
            m_axis_tdata <= fifo_dout;
            m_axis_tlast <= pop_last;
          end else begin
            tail_data <= fifo_dout;
            tail_last <= pop_last;
          end
          occ           <= occ + OCC_WIDTH'(1);
          m_axis_tvalid <= 1'b1;
        end
        2'b01: begin
          if (occ == OCC_WIDTH'(2)) begin
            m_axis_tdata <= tail_data;
            m_axis_tlast <= tail_last;
          end
          occ           <= occ - OCC_WIDTH'(1);
          m_axis_tvalid <= (occ != OCC_WIDTH'(1));
        end
        2'b11: begin
          // Pop needs occ<2 and accept needs occ>0, so occ is 1: replace head.
          m_axis_tdata <= fifo_dout;
          m_axis_tlast <= pop_last;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_to_axis.sv
// Directed bench for pp_pipeline_accel_fifo_to_axis with a queue-based FIFO
// source, a beat scoreboard and per-cycle AXIS/pop invariant checks.
module tb_pp_pipeline_accel_fifo_to_axis;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 16;
  localparam int unsigned KW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] pkt_len;
  logic          busy;
  logic          done;
  logic          fifo_empty_n;
  logic [DW-1:0] fifo_dout;
  logic          fifo_read;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [KW-1:0] m_axis_tkeep;

  pp_pipeline_accel_fifo_to_axis #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .KEEP_WIDTH(KW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pkt_len      (pkt_len),
    .busy         (busy),
    .done         (done),
    .fifo_empty_n (fifo_empty_n),
    .fifo_dout    (fifo_dout),
    .fifo_read    (fifo_read),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tkeep (m_axis_tkeep)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] expq[$];
  int checks = 0;
  int errors = 0;
  int beats, pops, dones, cyc, occ_m, cur_len;
  int rdy_mode, src_mode;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    fifo_empty_n  = (q.size() > 0) && (src_mode == 0 || (cyc % 5) == 0);
    fifo_dout     = (q.size() > 0) ? q[0] : '0;
    m_axis_tready = (rdy_mode == 0) || ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endtask

  // One clock: sample before the edge, update models after it, then re-drive.
  task automatic tick();
    logic          pop_now, acc_now, stall_now, last_now;
    logic [DW-1:0] d_now, w;
    pop_now   = fifo_read && fifo_empty_n;
    acc_now   = m_axis_tvalid && m_axis_tready;
    stall_now = m_axis_tvalid && !m_axis_tready;
    d_now     = m_axis_tdata;
    last_now  = m_axis_tlast;
    check("read_while_empty", DW'(fifo_read && !fifo_empty_n), '0);
    check("read_while_full", DW'(fifo_read && occ_m == 2), '0);
    @(posedge clk);
    #1;
    cyc++;
    if (acc_now) begin
      if (expq.size() == 0) begin
        check("beat_unexpected", DW'(1'b1), '0);
      end else begin
        w = expq.pop_front();
        check("beat_data", d_now, w);
      end
      check("beat_last", DW'(last_now), DW'(beats == cur_len - 1));
      beats++;
      occ_m--;
      if (last_now) begin
        check("done_after_last", DW'(done), DW'(1'b1));
        check("busy_after_last", DW'(busy), '0);
      end
    end
    if (pop_now) begin
      w = q.pop_front();
      expq.push_back(w);
      pops++;
      occ_m++;
    end
    if (occ_m > 2) check("occ_bound", DW'(occ_m), DW'(2));
    if (stall_now) begin
      check("stall_valid", DW'(m_axis_tvalid), DW'(1'b1));
      check("stall_data", m_axis_tdata, d_now);
      check("stall_last", DW'(m_axis_tlast), DW'(last_now));
    end
    if (done) dones++;
    drive_inputs();
    #1;
  endtask

  task automatic start_pkt(input int len);
    beats   = 0;
    pops    = 0;
    dones   = 0;
    cur_len = len;
    start   = 1'b1;
    pkt_len = LW'(len);
    tick();
    start   = 1'b0;
    pkt_len = '0;
    check("busy_after_start", DW'(busy), DW'(len != 0));
  endtask

  task automatic run_until_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_timeout", DW'(done), DW'(1'b1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pkt_len = '0;
    cyc = 0; occ_m = 0; rdy_mode = 0; src_mode = 0; cur_len = 0;
    beats = 0; pops = 0; dones = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_tvalid", DW'(m_axis_tvalid), '0);
    check("rst_tlast", DW'(m_axis_tlast), '0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_fifo_read", DW'(fifo_read), '0);
    check("tkeep", DW'(m_axis_tkeep), DW'(8'hFF));
    reset = 1'b0;
    tick();

    // Basic packet of 4 at full rate
    q.push_back(64'h11); q.push_back(64'h22); q.push_back(64'h33); q.push_back(64'h44);
    drive_inputs(); #1;
    start_pkt(4);
    check("basic_first_read", DW'(fifo_read), DW'(1'b1));
    tick();
    check("basic_latency_valid", DW'(m_axis_tvalid), DW'(1'b1));
    check("basic_latency_data", m_axis_tdata, 64'h11);
    run_until_done(20);
    check("basic_beats", DW'(beats), DW'(4));
    check("basic_pops", DW'(pops), DW'(4));
    tick();
    check("basic_done_pulse", DW'(done), '0);
    check("basic_dones", DW'(dones), DW'(1));

    // Backpressure with tready 1,0,0,1...
    for (int i = 0; i < 8; i++) q.push_back(64'hA0 + 64'(i));
    rdy_mode = 1; drive_inputs(); #1;
    start_pkt(8);
    run_until_done(100);
    check("bp_beats", DW'(beats), DW'(8));
    check("bp_pops", DW'(pops), DW'(8));
    rdy_mode = 0;

    // Starved source: empty_n every 5th cycle
    for (int i = 0; i < 3; i++) q.push_back(64'hC0DE_0000 + 64'(i));
    src_mode = 1; drive_inputs(); #1;
    start_pkt(3);
    run_until_done(100);
    check("starve_beats", DW'(beats), DW'(3));
    tick();
    check("starve_dones", DW'(dones), DW'(1));
    src_mode = 0; drive_inputs(); #1;

    // Zero length
    start_pkt(0);
    check("zero_done", DW'(done), DW'(1'b1));
    check("zero_tvalid", DW'(m_axis_tvalid), '0);
    tick();
    check("zero_done_pulse", DW'(done), '0);
    check("zero_pops", DW'(pops), '0);

    // Over-read guard: 5 words queued, only 2 taken
    for (int i = 0; i < 5; i++) q.push_back(64'hD0 + 64'(i));
    drive_inputs(); #1;
    start_pkt(2);
    run_until_done(20);
    repeat (5) tick();
    check("over_pops", DW'(pops), DW'(2));
    check("over_left", DW'(q.size()), DW'(3));
    check("over_beats", DW'(beats), DW'(2));
    q.delete(); drive_inputs(); #1;

    // Max packet then back-to-back start on the done cycle
    for (int i = 0; i < 65535; i++) q.push_back(64'hA5A5_0000_0000_0000 ^ 64'(i));
    drive_inputs(); #1;
    start_pkt(65535);
    run_until_done(70000);
    check("max_beats", DW'(beats), DW'(65535));
    check("max_pops", DW'(pops), DW'(65535));
    q.push_back(64'hBEEF); drive_inputs(); #1;
    start_pkt(1);
    run_until_done(20);
    check("b2b_beats", DW'(beats), DW'(1));
    check("b2b_dones", DW'(dones), DW'(1));

    // Reset mid-packet after beat 2 of 6
    for (int i = 0; i < 6; i++) q.push_back(64'hE0 + 64'(i));
    drive_inputs(); #1;
    start_pkt(6);
    for (int n = 0; n < 50 && beats < 2; n++) tick();
    check("rst_mid_beats", DW'(beats), DW'(2));
    reset = 1'b1;
    #1;
    check("rst_mid_tvalid", DW'(m_axis_tvalid), '0);
    check("rst_mid_busy", DW'(busy), '0);
    check("rst_mid_read", DW'(fifo_read), '0);
    q.delete(); expq.delete(); occ_m = 0;
    drive_inputs(); #1;
    tick();
    reset = 1'b0;
    q.push_back(64'h1234_5678); drive_inputs(); #1;
    start_pkt(1);
    run_until_done(20);
    check("post_rst_beats", DW'(beats), DW'(1));
    check("post_rst_pops", DW'(pops), DW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
